// File: rtl/seq_det_param.sv
// seq_det_param: parametrised serial sequence detector.
// Shifts accepted bits (x_vld=1) into a W-bit history and pulses y for one
// cycle whenever the last W accepted bits equal PATTERN (MSB received first).
// The overlap input selects overlapping or non-overlapping detection per bit.
// Optional feature: define SEQ_DET_COUNT_EN to build in the saturating
// match counter (match_cnt, clr_cnt). Without it match_cnt reads 0 and
// clr_cnt is ignored.
module seq_det_param #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = 4'b1010,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_vld,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    // Fill counter must represent 0..W inclusive.
    localparam int             FW   = $clog2(W + 1);
    localparam logic [FW-1:0]  FULL = FW'(W);

    logic [W-1:0]  hist;
    logic [W-1:0]  nxt;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_nxt;
    logic          match;

    // Next history, saturating fill and match decision for the current bit.
    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        nxt      = {hist[W-2:0], x};
        fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
        match    = x_vld && (fill_nxt == FULL) && (nxt == PATTERN);
    end

    // History, fill level and registered match pulse.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
        end else begin
            y <= match;
            if (x_vld) begin
                hist <= nxt;
                // Non-overlapping mode: a match empties the history so the
                // next match needs W fresh bits.
                fill <= (match && !overlap) ? '0 : fill_nxt;
            end
        end
    end

    // The oldest history bit only ever shifts out; it is never compared.
    logic unused_hist_msb;
    assign unused_hist_msb = hist[W-1];

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating match counter; a clear coinciding with a match counts that match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= match ? CNT_W'(1) : '0;
        end else if (match && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign match_cnt = cnt;
`else
    assign match_cnt = '0;

    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: scoreboard bench for seq_det_param.
// Two instances share the stimulus: A (W=4, 1010, CNT_W=2) and
// B (W=3, 111, CNT_W=4, exercises back-to-back overlapping matches).
// The reference model keeps the list of accepted bits since the history was
// last emptied and compares its numeric value with the pattern.
module tb_seq_det_param;

    typedef struct {
        bit y;
        int cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       x;
    logic       x_vld;
    logic       overlap;
    logic       clr_cnt;
    logic       y_a;
    logic [1:0] cnt_a;
    logic       y_b;
    logic [3:0] cnt_b;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int mw   [2];
    int mp   [2];
    int mmax [2];
    bit hb   [2][32];
    int hl   [2];
    int mcnt [2];

    exp_t q0[$];
    exp_t q1[$];

    seq_det_param #(.W(4), .PATTERN(4'b1010), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .x(x), .x_vld(x_vld), .overlap(overlap),
        .clr_cnt(clr_cnt), .y(y_a), .match_cnt(cnt_a)
    );

    seq_det_param #(.W(3), .PATTERN(3'b111), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .x(x), .x_vld(x_vld), .overlap(overlap),
        .clr_cnt(clr_cnt), .y(y_b), .match_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Advance the model by one clock edge and queue the expected outputs.
    task automatic model_edge(input bit xi, input bit vi, input bit ov, input bit cl);
        for (int i = 0; i < 2; i++) begin
            bit   m;
            int   val;
            exp_t e;
            m = 1'b0;
            if (vi) begin
                if (hl[i] == mw[i]) begin
                    for (int k = 0; k < mw[i] - 1; k++) hb[i][k] = hb[i][k+1];
                    hb[i][mw[i]-1] = xi;
                end else begin
                    hb[i][hl[i]] = xi;
                    hl[i]++;
                end
                if (hl[i] == mw[i]) begin
                    val = 0;
                    for (int k = 0; k < mw[i]; k++) val = val * 2 + int'(hb[i][k]);
                    m = (val == mp[i]);
                end
                if (m && !ov) hl[i] = 0;
            end
`ifdef SEQ_DET_COUNT_EN
            if (cl)                          mcnt[i] = m ? 1 : 0;
            else if (m && mcnt[i] < mmax[i]) mcnt[i]++;
`else
            mcnt[i] = cl ? 0 : 0;
`endif
            e.y   = m;
            e.cnt = mcnt[i];
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic drive(input bit xi, input bit vi, input bit ov, input bit cl);
        @(negedge clk);
        x       = xi;
        x_vld   = vi;
        overlap = ov;
        clr_cnt = cl;
        model_edge(xi, vi, ov, cl);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic reset_pulse();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_y_a",   32'(y_a),   32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_y_b",   32'(y_b),   32'd0);
        check("rst_cnt_b", 32'(cnt_b), 32'd0);
        for (int i = 0; i < 2; i++) begin
            hl[i]   = 0;
            mcnt[i] = 0;
        end
        #1 rst = 1'b0;
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) drive(bits[i], 1'b1, ov, 1'b0);
    endtask

    // Monitor: compare outputs shortly after every edge that has an expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check("a_y",   32'(y_a),   32'(e.y));
            check("a_cnt", 32'(cnt_a), 32'(e.cnt));
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("b_y",   32'(y_b),   32'(e.y));
            check("b_cnt", 32'(cnt_b), 32'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mw   = '{4, 3};
        mp   = '{10, 7};
        mmax = '{3, 15};
        hl   = '{0, 0};
        mcnt = '{0, 0};
        x = 1'b0; x_vld = 1'b0; overlap = 1'b0; clr_cnt = 1'b0;
        rst = 1'b1;
        #3;
        check("init_y_a",   32'(y_a),   32'd0);
        check("init_cnt_a", 32'(cnt_a), 32'd0);
        check("init_y_b",   32'(y_b),   32'd0);
        check("init_cnt_b", 32'(cnt_b), 32'd0);
        #5 rst = 1'b0;

        // Overlapping: 101010 -> A matches on bits 4 and 6.
        drive_bits(16'b101010, 6, 1'b1);
        reset_pulse();

        // Non-overlapping: 10101010 -> A matches on bits 4 and 8 only.
        drive_bits(16'b10101010, 8, 1'b0);
        reset_pulse();

        // Valid gaps: 1,0, three idle cycles, 1,0 -> one pulse after the last 0.
        drive_bits(16'b10, 2, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        drive_bits(16'b10, 2, 1'b1);

        // Reset mid-sequence: 1,0,1, reset, 0 -> no match.
        reset_pulse();
        drive_bits(16'b101, 3, 1'b1);
        reset_pulse();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        reset_pulse();

        // Saturation on A (CNT_W=2): five 10 pairs, then clear on a matching edge.
        drive_bits(16'b1010101010, 10, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        reset_pulse();

        // All-ones bursts for B: back-to-back in overlap, every third bit otherwise.
        drive_bits(16'b111111, 6, 1'b1);
        reset_pulse();
        drive_bits(16'b111111, 6, 1'b0);
        reset_pulse();

        // Randomised traffic with occasional clears, mode toggles and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse();
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 19) == 0));
        end

        @(posedge clk);
        #3;
        check("drain", 32'(q0.size() + q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
